// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC sequencer: owns pc, drives imem, buffers one instruction.
// Optional MISALIGN_TRAP_EN: misaligned redirect traps until reset.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        flush,
  output logic        misaligned
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;
`ifdef MISALIGN_TRAP_EN
  localparam logic [1:0] S_TRAP  = 2'd3;
`endif

  // Counter runs FLUSH_CYCLES-1 down to 0, one flush cycle per value.
  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [29:0] tgt_q, tgt_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic [29:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;

  logic cap;
  logic jump_ok;
  logic tgt_mis;

  assign imem_req    = (state_q == S_FETCH) && !(valid_q && stall);
  assign imem_addr   = {pc_q, 2'b00};
  assign instr       = instr_q;
  assign instr_pc    = {ipc_q, 2'b00};
  assign instr_valid = valid_q;
  assign misaligned  = mis_q;

`ifdef MISALIGN_TRAP_EN
  assign flush   = (state_q == S_REDIR) || (state_q == S_TRAP);
  assign jump_ok = jump_en && (state_q != S_TRAP);
`else
  assign flush   = (state_q == S_REDIR);
  assign jump_ok = jump_en;
`endif

  assign cap     = imem_req && imem_ready;
  assign tgt_mis = |jump_target[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = stall ? valid_q : 1'b0;
    mis_d   = 1'b0;

    if (jump_ok) begin
      // Redirect wins over stall and any same-cycle memory return.
      valid_d = 1'b0;
      tgt_d   = jump_target[31:2];
      cnt_d   = CNT_LOAD;
      mis_d   = tgt_mis;
`ifdef MISALIGN_TRAP_EN
      state_d = tgt_mis ? S_TRAP : S_REDIR;
`else
      state_d = S_REDIR;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (cap) begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 30'd1;
          end
        end
        S_REDIR: begin
          if (cnt_q == 3'd0) begin
            state_d = S_FETCH;
            pc_d    = tgt_q;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC[31:2];
      tgt_q   <= 30'd0;
      cnt_q   <= 3'd0;
      instr_q <= 32'd0;
      ipc_q   <= 30'd0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Fetch-stage PC sequencer directly upstream of the jump/link resolution stage.
- Owns the program counter, issues instruction-memory requests, presents fetched instruction + PC to decode.
- Accepts redirects carrying the jump target computed downstream, and produces a flush for the wrong-path instruction(s) after a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FLUSH_CYCLES, 2, bubble cycles (flush high) after an accepted redirect; legal 1..7

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
stall  input  1  decode cannot accept; hold held instruction
jump_en  input  1  redirect valid (jal/jalr resolved), one-cycle pulse
jump_target  input  32  redirect address
imem_ready  input  1  memory returns data for current imem_addr this cycle
imem_rdata  input  32  instruction word, valid with imem_ready
imem_req  output  1  fetch request, held until imem_ready
imem_addr  output  32  fetch address (= pc), stable while imem_req high
instr  output  32  fetched instruction to decode
instr_pc  output  32  PC of instr
instr_valid  output  1  instr/instr_pc hold a valid instruction
flush  output  1  kill wrong-path instruction in downstream stage
misaligned  output  1  one-cycle pulse: jump_target[1:0] != 0

Behaviour:
- Reset (rst high at clk edge, any state, overrides all inputs):
  - pc = RESET_PC; state = IDLE.
  - imem_req = 0, instr = 0, instr_pc = 0, instr_valid = 0, flush = 0, misaligned = 0, flush counter = 0.
- States:
  - IDLE: one cycle after reset, imem_req = 0 -> FETCH.
  - FETCH: imem_req = 1 unless (instr_valid && stall); imem_addr = pc.
    - On imem_ready with imem_req = 1: instr <= imem_rdata, instr_pc <= pc, instr_valid <= 1, pc <= pc + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
  - REDIRECT: imem_req = 0, flush = 1, counter decrements from FLUSH_CYCLES.
    - At count 0 -> FETCH with pc = target captured at redirect.
- Instruction buffer:
  - instr_valid clears on any edge where stall = 0 and no new capture occurs.
  - While stall = 1, instr, instr_pc and instr_valid hold.
  - No new request is issued while the buffer is full and stalled. A request already held (imem_req = 1 and address stable) stays asserted only if the buffer is empty.
- Fetch latency: imem_ready in cycle N -> instr_valid high in cycle N+1. Back-to-back fetches sustain 1 instr/cycle with single-cycle memory.
- Redirect (jump_en = 1, state FETCH or IDLE):
  - Highest priority after rst.
  - Any imem_ready in the same cycle is ignored: no capture, pc not incremented.
  - instr_valid <= 0; target latched; -> REDIRECT next cycle.
- jump_en during REDIRECT: new target replaces old; counter reloads to FLUSH_CYCLES.
- jump_en with stall = 1: still accepted; the redirect overrides the stall.
- misaligned: pulses the cycle after jump_en when jump_target[1:0] != 0. Target handling is set by the optional feature.
- imem_addr[1:0] always 2'b00.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a misaligned redirect enters TRAP instead of REDIRECT.
  - TRAP: imem_req = 0, instr_valid = 0, flush = 1, misaligned pulses once.
  - Exit only via rst.
- Undefined: no TRAP state; jump_target[1:0] forced to 2'b00 and the redirect proceeds normally; misaligned still pulses as a diagnostic.

Test Plan:
- Reset, single-cycle memory returning 32'h0000_0013 every cycle -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; instr_pc lags by one cycle; instr_valid high from cycle 3.
- stall high for 3 cycles after capture of pc 0x8 -> instr_pc holds 0x8, imem_req low, pc holds 0xC; stall drops -> fetch of 0xC resumes next cycle.
- jump_en with target 0x100 while imem_ready high at pc 0x10 -> no capture, flush high 2 cycles, next imem_addr = 0x100, instr_pc 0x100 follows.
- Second jump_en (target 0x200) during REDIRECT of 0x100 -> counter reloads, 0x100 never fetched, next imem_addr = 0x200.
- jump_target 0x102: without macro -> misaligned pulse, fetch resumes at 0x100. With MISALIGN_TRAP_EN -> TRAP, imem_req stays 0 until rst.
- rst asserted mid-REDIRECT and mid-stall -> all outputs return to reset values next edge; fetch restarts at RESET_PC.
